wb_slave_receive_interface: RTL and testbench

WISHBONE pipelined slave port of the NIC, the responding end of the bus that wb_master_interface drives.
- Accepts single and burst (pipelined) cycles from a local bus master and buffers every beat.
- At end of cycle, hands the whole message to the NIC packetizer queue one chunk at a time.
- Write beats are ACKed here. Read beats are only captured and forwarded as a request; their ACK is produced elsewhere when the reply returns.

---
 rtl/wb_slave_receive_interface_if.sv | 51 +++++
 rtl/wb_slave_receive_interface.sv | 187 ++++++++++++++++++
 tb/tb_wb_slave_receive_interface.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_receive_interface_if.sv
// ============================================================================
//  Module      : wb_slave_receive_interface_if
//  Description : WISHBONE pipelined bus bundle between a local bus master and
//                the NIC receive slave port. Also supplies default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef GRANULARITY
`define GRANULARITY 8
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 4
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 4
`endif

interface wb_slave_receive_interface_if;
    logic                                         CYC_I;
    logic                                         STB_I;
    logic                                         WE_I;
    logic [`BUS_ADDRESS_WIDTH-1:0]                ADR_I;
    logic [`BUS_DATA_WIDTH-1:0]                   DAT_I;
    logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]      SEL_I;
    logic [`BUS_TGA_WIDTH-1:0]                    TGA_I;
    logic [`BUS_TGC_WIDTH-1:0]                    TGC_I;
    logic                                         ACK_O;
    logic                                         ERR_O;
    logic                                         STALL_O;

    // Bus master side: drives the cycle, observes the handshake
    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I,
        input  ACK_O, ERR_O, STALL_O
    );

    // Slave side: the NIC receive port
    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I,
        output ACK_O, ERR_O, STALL_O
    );
endinterface

`default_nettype wire

// File: rtl/wb_slave_receive_interface.sv
// ============================================================================
//  Module      : wb_slave_receive_interface
//  Description : WISHBONE pipelined slave port of the NIC. Buffers every beat
//                of a single or burst cycle, then hands the message to the
//                packetizer queue one chunk at a time. Write beats are ACKed
//                here; read beats are only captured and forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_slave_receive_interface #(
    parameter int N_BITS_BURST_LENGHT = 4,
    parameter int BUFFER_DEPTH        = 8
) (
    input  wire logic                                     clk,
    input  wire logic                                     rst,
    wb_slave_receive_interface_if.slave                   bus,
    output logic                                          message_valid_o,
    output logic [`BUS_ADDRESS_WIDTH-1:0]                 address_o,
    output logic [`BUS_DATA_WIDTH-1:0]                    data_o,
    output logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]       sel_o,
    output logic [`BUS_TGA_WIDTH-1:0]                     tga_o,
    output logic [`BUS_TGC_WIDTH-1:0]                     tgc_o,
    output logic                                          transaction_type_o,
    output logic [N_BITS_BURST_LENGHT-1:0]                burst_lenght_o,
    output logic                                          message_error_o,
    input  wire logic                                     next_data_i
);

    localparam int                         PTR_W     = $clog2(BUFFER_DEPTH);
    localparam int                         SEL_W     = `BUS_DATA_WIDTH/`GRANULARITY;
    localparam logic [N_BITS_BURST_LENGHT-1:0] DEPTH_CNT = BUFFER_DEPTH[N_BITS_BURST_LENGHT-1:0];
    localparam logic [N_BITS_BURST_LENGHT-1:0] CNT_ONE   = {{(N_BITS_BURST_LENGHT-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RECEIVE = 2'd1;
    localparam logic [1:0] HANDOFF = 2'd2;

    logic [1:0]                     state;
    logic [1:0]                     next_state;
    logic [N_BITS_BURST_LENGHT-1:0] wr_ptr;
    logic [N_BITS_BURST_LENGHT-1:0] rd_ptr;
    logic [N_BITS_BURST_LENGHT-1:0] count;
    logic                           msg_type;
    logic                           msg_err;
    logic                           ack_pulse;
    logic                           err_pulse;

    logic                           stall;
    logic                           msg_valid;
    logic                           accept;
    logic                           type_match;
    logic                           store;
    logic                           pop;
    logic                           last_chunk;
    logic                           pending_ack_conflict;

    // Message buffer: no reset, contents are only read while a message is valid
    logic [`BUS_ADDRESS_WIDTH-1:0]  buf_adr [BUFFER_DEPTH];
    logic [`BUS_DATA_WIDTH-1:0]     buf_dat [BUFFER_DEPTH];
    logic [SEL_W-1:0]               buf_sel [BUFFER_DEPTH];
    logic [`BUS_TGA_WIDTH-1:0]      buf_tga [BUFFER_DEPTH];
    logic [`BUS_TGC_WIDTH-1:0]      buf_tgc [BUFFER_DEPTH];

    // Reserved hook for a future read/write ACK ordering conflict
    assign pending_ack_conflict = 1'b0;

    // The first beat of a cycle defines the message type; later beats must match
    assign accept     = bus.CYC_I & bus.STB_I & ~stall;
    assign type_match = (state == IDLE) | (bus.WE_I == msg_type);
    assign store      = accept & type_match;
    assign pop        = msg_valid & next_data_i;
    assign last_chunk = (rd_ptr == (count - CNT_ONE));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)            next_state = RECEIVE;
            RECEIVE: if (!bus.CYC_I)        next_state = HANDOFF;
            HANDOFF: if (pop && last_chunk) next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    // State-decoded outputs: stall while full, or hold off a new cycle during handoff
    always_comb begin
        stall     = 1'b0;
        msg_valid = 1'b0;
        case (state)
            RECEIVE: stall = (count == DEPTH_CNT) | pending_ack_conflict;
            HANDOFF: begin
                stall     = bus.CYC_I;
                msg_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Pointers, counters, message flags and the registered ACK/ERR pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            msg_type  <= 1'b0;
            msg_err   <= 1'b0;
            ack_pulse <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            ack_pulse <= store & bus.WE_I;
            err_pulse <= accept & ~type_match;
            case (state)
                IDLE: begin
                    if (accept) begin
                        msg_type <= bus.WE_I;
                        msg_err  <= 1'b0;
                        count    <= CNT_ONE;
                        wr_ptr   <= CNT_ONE;
                        rd_ptr   <= '0;
                    end
                end
                RECEIVE: begin
                    if (store) begin
                        wr_ptr <= wr_ptr + CNT_ONE;
                        count  <= count + CNT_ONE;
                    end
                    if (accept && !type_match) begin
                        msg_err <= 1'b1;
                    end
                end
                HANDOFF: begin
                    if (pop) begin
                        if (last_chunk) begin
                            wr_ptr   <= '0;
                            rd_ptr   <= '0;
                            count    <= '0;
                            msg_type <= 1'b0;
                            msg_err  <= 1'b0;
                        end else begin
                            rd_ptr <= rd_ptr + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat capture into the message buffer
    always_ff @(posedge clk) begin
        if (store) begin
            buf_adr[wr_ptr[PTR_W-1:0]] <= bus.ADR_I;
            buf_dat[wr_ptr[PTR_W-1:0]] <= bus.DAT_I;
            buf_sel[wr_ptr[PTR_W-1:0]] <= bus.SEL_I;
            buf_tga[wr_ptr[PTR_W-1:0]] <= bus.TGA_I;
            buf_tgc[wr_ptr[PTR_W-1:0]] <= bus.TGC_I;
        end
    end

    assign bus.ACK_O   = ack_pulse;
    assign bus.ERR_O   = err_pulse;
    assign bus.STALL_O = stall;

    // Head chunk is forced to zero outside handoff so reset leaves every output at 0
    assign message_valid_o    = msg_valid;
    assign address_o          = msg_valid ? buf_adr[rd_ptr[PTR_W-1:0]] : '0;
    assign data_o             = msg_valid ? buf_dat[rd_ptr[PTR_W-1:0]] : '0;
    assign sel_o              = msg_valid ? buf_sel[rd_ptr[PTR_W-1:0]] : '0;
    assign tga_o              = msg_valid ? buf_tga[rd_ptr[PTR_W-1:0]] : '0;
    assign tgc_o              = msg_valid ? buf_tgc[rd_ptr[PTR_W-1:0]] : '0;
    assign transaction_type_o = msg_type;
    assign burst_lenght_o     = msg_valid ? count : '0;
    assign message_error_o    = msg_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_slave_receive_interface.sv
// ============================================================================
//  Module      : tb_wb_slave_receive_interface
//  Description : Directed self-checking bench for wb_slave_receive_interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_slave_receive_interface;

    logic clk;
    logic rst;
    logic next_data_i;

    logic                                    message_valid_o;
    logic [`BUS_ADDRESS_WIDTH-1:0]           address_o;
    logic [`BUS_DATA_WIDTH-1:0]              data_o;
    logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0] sel_o;
    logic [`BUS_TGA_WIDTH-1:0]               tga_o;
    logic [`BUS_TGC_WIDTH-1:0]               tgc_o;
    logic                                    transaction_type_o;
    logic [3:0]                              burst_lenght_o;
    logic                                    message_error_o;

    int n_checks = 0;
    int n_fail   = 0;
    int acks;

    wb_slave_receive_interface_if bus ();

    wb_slave_receive_interface #(
        .N_BITS_BURST_LENGHT (4),
        .BUFFER_DEPTH        (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .message_valid_o    (message_valid_o),
        .address_o          (address_o),
        .data_o             (data_o),
        .sel_o              (sel_o),
        .tga_o              (tga_o),
        .tgc_o              (tgc_o),
        .transaction_type_o (transaction_type_o),
        .burst_lenght_o     (burst_lenght_o),
        .message_error_o    (message_error_o),
        .next_data_i        (next_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = we;
        bus.ADR_I = adr;
        bus.DAT_I = dat;
        bus.SEL_I = '1;
        bus.TGA_I = 4'h3;
        bus.TGC_I = 4'h5;
    endtask

    task automatic idle_bus();
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
    endtask

    task automatic pop_chunk();
        next_data_i = 1'b1;
        tick();
        next_data_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        next_data_i = 1'b0;
        bus.ADR_I   = '0;
        bus.DAT_I   = '0;
        bus.SEL_I   = '0;
        bus.TGA_I   = '0;
        bus.TGC_I   = '0;
        idle_bus();
        tick();
        tick();

        // Reset state
        check("rst_ack",   bus.ACK_O, 0);
        check("rst_err",   bus.ERR_O, 0);
        check("rst_stall", bus.STALL_O, 0);
        check("rst_valid", message_valid_o, 0);
        check("rst_burst", burst_lenght_o, 0);
        check("rst_data",  data_o, 0);
        check("rst_merr",  message_error_o, 0);
        rst = 1'b1;
        tick();

        // 1: single write
        drive_beat(1'b1, 32'h10, 32'hA5);
        tick();
        check("t1_ack", bus.ACK_O, 1);
        idle_bus();
        tick();
        check("t1_ack_drop", bus.ACK_O, 0);
        check("t1_valid", message_valid_o, 1);
        check("t1_burst", burst_lenght_o, 1);
        check("t1_data",  data_o, 32'hA5);
        check("t1_addr",  address_o, 32'h10);
        check("t1_sel",   sel_o, 4'hF);
        check("t1_tga",   tga_o, 4'h3);
        check("t1_type",  transaction_type_o, 1);
        pop_chunk();
        check("t1_valid_off", message_valid_o, 0);

        // 2: 4-beat pipelined write
        for (int i = 0; i < 4; i++) begin
            drive_beat(1'b1, 32'h20 + i, 32'h100 + i);
            tick();
            check($sformatf("t2_ack%0d", i), bus.ACK_O, 1);
        end
        idle_bus();
        tick();
        check("t2_ack_end", bus.ACK_O, 0);
        check("t2_burst", burst_lenght_o, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_data%0d", i), data_o, 32'h100 + i);
            pop_chunk();
        end
        check("t2_valid_off", message_valid_o, 0);

        // 3: 10-beat write into an 8-deep buffer
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            drive_beat(1'b1, 32'h80, 32'h300 + i);
            tick();
            if (bus.ACK_O) acks++;
            if (i == 6) check("t3_stall_before_full", bus.STALL_O, 0);
            if (i == 7) check("t3_stall_full", bus.STALL_O, 1);
        end
        check("t3_stall_held", bus.STALL_O, 1);
        idle_bus();
        tick();
        check("t3_acks", acks, 8);
        check("t3_burst", burst_lenght_o, 8);
        check("t3_stall_idle_bus", bus.STALL_O, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) check("t3_first", data_o, 32'h300);
            if (i == 7) check("t3_last",  data_o, 32'h307);
            pop_chunk();
        end
        check("t3_valid_off", message_valid_o, 0);

        // 4: 2-beat read
        drive_beat(1'b0, 32'h40, 32'h0);
        tick();
        check("t4_noack0", bus.ACK_O, 0);
        drive_beat(1'b0, 32'h44, 32'h0);
        tick();
        check("t4_noack1", bus.ACK_O, 0);
        idle_bus();
        tick();
        check("t4_noack2", bus.ACK_O, 0);
        check("t4_type",  transaction_type_o, 0);
        check("t4_burst", burst_lenght_o, 2);
        check("t4_addr0", address_o, 32'h40);
        pop_chunk();
        check("t4_addr1", address_o, 32'h44);
        pop_chunk();
        check("t4_valid_off", message_valid_o, 0);

        // 5: write burst with a read beat in the middle
        drive_beat(1'b1, 32'h50, 32'h500);
        tick();
        check("t5_ack0", bus.ACK_O, 1);
        check("t5_err0", bus.ERR_O, 0);
        drive_beat(1'b0, 32'h54, 32'h501);
        tick();
        check("t5_ack1", bus.ACK_O, 0);
        check("t5_err1", bus.ERR_O, 1);
        drive_beat(1'b1, 32'h58, 32'h502);
        tick();
        check("t5_ack2", bus.ACK_O, 1);
        check("t5_err2", bus.ERR_O, 0);
        idle_bus();
        tick();
        check("t5_burst", burst_lenght_o, 2);
        check("t5_merr",  message_error_o, 1);
        check("t5_addr0", address_o, 32'h50);
        pop_chunk();
        check("t5_addr1", address_o, 32'h58);
        pop_chunk();
        check("t5_merr_clr", message_error_o, 0);

        // 6a: new cycle during handoff is stalled until the last pop
        drive_beat(1'b1, 32'h90, 32'h600);
        tick();
        idle_bus();
        tick();
        drive_beat(1'b1, 32'h94, 32'h601);
        #1;
        check("t6_stall_handoff", bus.STALL_O, 1);
        next_data_i = 1'b1;
        tick();
        next_data_i = 1'b0;
        check("t6_idle_stall", bus.STALL_O, 0);
        check("t6_no_ack_stalled", bus.ACK_O, 0);
        check("t6_valid_off", message_valid_o, 0);
        tick();
        check("t6_ack_new", bus.ACK_O, 1);
        idle_bus();
        tick();
        check("t6_burst", burst_lenght_o, 1);
        check("t6_data",  data_o, 32'h601);
        pop_chunk();

        // 6b: asynchronous reset mid-RECEIVE
        drive_beat(1'b1, 32'hA0, 32'h700);
        tick();
        check("t6_pre_rst_ack", bus.ACK_O, 1);
        drive_beat(1'b1, 32'hA4, 32'h701);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_ack",   bus.ACK_O, 0);
        check("t6_rst_err",   bus.ERR_O, 0);
        check("t6_rst_stall", bus.STALL_O, 0);
        check("t6_rst_valid", message_valid_o, 0);
        idle_bus();
        rst = 1'b1;
        tick();
        tick();
        check("t6_post_valid", message_valid_o, 0);
        check("t6_post_ack",   bus.ACK_O, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
